jk_reg_bank: RTL and testbench

- Parametrised successor to the single-bit JK storage element: a WIDTH-bit bank of edge-triggered JK flip-flops sharing one clock and one asynchronous reset.
- Adds a clock enable, a synchronous load mode, and a JK-toggle-chain up/down counter mode with terminal-count flag and change strobe.
- Used as the general-purpose JK register/counter primitive for the sequential-circuits library.

---
 rtl/jk_reg_bank.sv | 80 ++++++++
 tb/tb_jk_reg_bank.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with clock enable, synchronous load and
// a JK toggle-chain up/down counter mode with terminal-count and change flags.
module jk_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             chg
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] q_next;

    assign op = mode_t'(mode);

    // Counter modes drive every bit's J and K together, so each bit toggles
    // exactly when its chain term is 1: bit i sees the AND of lower bits.
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        q_next = q;
        case (op)
            MODE_JK:   q_next = (j & ~q) | (~k & q);
            MODE_UP:   q_next = q ^ up_t;
            MODE_DOWN: q_next = q ^ dn_t;
            MODE_LOAD: q_next = j;
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            q   <= RESET_VAL;
            chg <= 1'b0;
        end else if (en) begin
            q   <= q_next;
            chg <= (q_next != q);
        end else begin
            chg <= 1'b0;
        end
    end

    assign qbar = ~q;

    always_comb begin
        tc = 1'b0;
        case (op)
            MODE_UP:   tc = &q;
            MODE_DOWN: tc = ~|q;
            default:   tc = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank at WIDTH=4, RESET_VAL=4'h5.
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rest = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       tc;
    logic       chg;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'h5)) dut (
        .clk(clk), .rest(rest), .en(en), .mode(mode), .j(j), .k(k),
        .q(q), .qbar(qbar), .tc(tc), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rest = 1'b1;
        #1;
        vectors++; if (q !== 4'h5) begin miscompares++; $display("FAIL reset_q got %h expected 5", q); end
        vectors++; if (qbar !== 4'hA) begin miscompares++; $display("FAIL reset_qbar got %h expected a", qbar); end
        vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL reset_chg got %b expected 0", chg); end
        step();
        vectors++; if (q !== 4'h5) begin miscompares++; $display("FAIL reset_hold got %h expected 5", q); end
        rest = 1'b0;
    endtask

    task automatic test_hold_en0();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = 2'(i);
            j = 4'(i * 5 + 3);
            k = 4'(~(i * 3));
            step();
            vectors++; if (q !== 4'h5) begin miscompares++; $display("FAIL en0_hold[%0d] got %h expected 5", i, q); end
            vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL en0_chg[%0d] got %b expected 0", i, chg); end
        end
    endtask

    task automatic test_jk();
        en = 1'b1; mode = 2'b00; j = 4'b1100; k = 4'b1010;
        #1;
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL jk_tc got %b expected 0", tc); end
        step();
        vectors++; if (q !== 4'b1101) begin miscompares++; $display("FAIL jk_mixed got %b expected 1101", q); end
        vectors++; if (chg !== 1'b1) begin miscompares++; $display("FAIL jk_chg got %b expected 1", chg); end
        j = 4'b0000; k = 4'b0000;
        step();
        vectors++; if (q !== 4'b1101) begin miscompares++; $display("FAIL jk_hold got %b expected 1101", q); end
        vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL jk_hold_chg got %b expected 0", chg); end
        j = 4'b1111; k = 4'b1111;
        step();
        vectors++; if (q !== 4'b0010) begin miscompares++; $display("FAIL jk_toggle got %b expected 0010", q); end
        j = 4'b0000; k = 4'b0010;
        step();
        vectors++; if (q !== 4'b0000) begin miscompares++; $display("FAIL jk_clear got %b expected 0000", q); end
    endtask

    task automatic test_load();
        mode = 2'b11; j = 4'hE; k = 4'h3;
        #1;
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL load_tc got %b expected 0", tc); end
        step();
        vectors++; if (q !== 4'hE) begin miscompares++; $display("FAIL load_q got %h expected e", q); end
        vectors++; if (chg !== 1'b1) begin miscompares++; $display("FAIL load_chg got %b expected 1", chg); end
    endtask

    task automatic test_count_up();
        mode = 2'b01; j = 4'h0; k = 4'hF;
        #1;
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL up_tc_e got %b expected 0", tc); end
        step();
        vectors++; if (q !== 4'hF) begin miscompares++; $display("FAIL up_f got %h expected f", q); end
        vectors++; if (tc !== 1'b1) begin miscompares++; $display("FAIL up_tc_f got %b expected 1", tc); end
        step();
        vectors++; if (q !== 4'h0) begin miscompares++; $display("FAIL up_wrap got %h expected 0", q); end
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL up_tc_0 got %b expected 0", tc); end
        vectors++; if (chg !== 1'b1) begin miscompares++; $display("FAIL up_wrap_chg got %b expected 1", chg); end
        step();
        vectors++; if (q !== 4'h1) begin miscompares++; $display("FAIL up_1 got %h expected 1", q); end
    endtask

    task automatic test_count_down();
        mode = 2'b10;
        #1;
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL dn_tc_1 got %b expected 0", tc); end
        step();
        vectors++; if (q !== 4'h0) begin miscompares++; $display("FAIL dn_0 got %h expected 0", q); end
        vectors++; if (tc !== 1'b1) begin miscompares++; $display("FAIL dn_tc_0 got %b expected 1", tc); end
        step();
        vectors++; if (q !== 4'hF) begin miscompares++; $display("FAIL dn_wrap got %h expected f", q); end
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL dn_tc_f got %b expected 0", tc); end
        step();
        vectors++; if (q !== 4'hE) begin miscompares++; $display("FAIL dn_e got %h expected e", q); end
        // Reach zero again and freeze it with en low.
        mode = 2'b11; j = 4'h0;
        step();
        mode = 2'b10; en = 1'b0;
        step();
        vectors++; if (q !== 4'h0) begin miscompares++; $display("FAIL dn_en0_q got %h expected 0", q); end
        vectors++; if (tc !== 1'b1) begin miscompares++; $display("FAIL dn_en0_tc got %b expected 1", tc); end
        vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL dn_en0_chg got %b expected 0", chg); end
        mode = 2'b01;
        #1;
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL mode_sw_tc got %b expected 0", tc); end
    endtask

    task automatic test_reset_mid_count();
        en = 1'b1; mode = 2'b11; j = 4'h8;
        step();
        mode = 2'b01;
        step();
        vectors++; if (q !== 4'h9) begin miscompares++; $display("FAIL mid_pre got %h expected 9", q); end
        #3 rest = 1'b1;
        #1;
        vectors++; if (q !== 4'h5) begin miscompares++; $display("FAIL mid_rst_q got %h expected 5", q); end
        vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL mid_rst_chg got %b expected 0", chg); end
        step();
        vectors++; if (q !== 4'h5) begin miscompares++; $display("FAIL mid_rst_hold got %h expected 5", q); end
        rest = 1'b0;
        step();
        vectors++; if (q !== 4'h6) begin miscompares++; $display("FAIL mid_release got %h expected 6", q); end
        vectors++; if (chg !== 1'b1) begin miscompares++; $display("FAIL mid_release_chg got %b expected 1", chg); end
    endtask

    initial begin
        test_reset();
        test_hold_en0();
        test_jk();
        test_load();
        test_count_up();
        test_count_down();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
